entrada_base_bin: RTL and testbench
===================================

Name: entrada_base_bin

Overview:
- Sequential digit-entry converter: accepts one 4-bit digit per handshake in the selected base (decimal, octal or hex) and accumulates an 8-bit binary operand for the ALU.
- Performs the reverse of the binary-to-BCD/octal/hex display path, with the same `sel` encoding.
- Sits between the keypad/switch debouncer and the ALU operand registers.
- `valor_vivo` is fed back to the display path so the user sees the partial entry.

Parameters:
- MAX_DIG_DEC, 3, maximum digits accepted in decimal mode
- MAX_DIG_OC, 3, maximum digits accepted in octal mode
- MAX_DIG_HEX, 2, maximum digits accepted in hex mode

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- sel  input  2  base select: 01=Dec (10), 10=Hex (16), 11=Oc (8), 00=no base
- digito  input  4  digit value, unsigned
- digito_valid  input  1  digit offered this cycle
- digito_ready  output  1  digit accepted when valid&&ready
- limpar  input  1  abort entry, clear accumulator
- confirmar  input  1  end entry, publish result
- valor  output  8  committed binary result
- valor_valid  output  1  one-cycle pulse when `valor` updates
- valor_vivo  output  8  low 8 bits of running accumulator
- overflow  output  1  committed result exceeded 255 (saturated)
- erro_digito  output  1  one-cycle pulse: offered digit rejected
- num_dig  output  2  digits accepted in current entry

Behaviour:
- Reset (async, `rst_n`=0):
  - state=ENTRADA; acc (10-bit)=0; num_dig=0; base lock cleared.
  - valor=0, valor_valid=0, valor_vivo=0, overflow=0, erro_digito=0.
- States:
  - ENTRADA -> CONCLUIDO on `confirmar`.
  - CONCLUIDO -> ENTRADA unconditionally after 1 cycle.
  - `limpar` in any state -> ENTRADA with acc=0, num_dig=0, base unlocked; `valor`/`overflow` unchanged.
- Ready: `digito_ready` = (state==ENTRADA) && !limpar && !confirmar (combinational).
- Base lock:
  - `sel` is sampled on the first accepted digit of an entry and held until commit or clear.
  - `sel` changes mid-entry are ignored.
  - With num_dig=0, the current `sel` applies.
- Digit acceptance (valid&&ready) on a clock edge:
  - If base=none (sel=00), OR digito>=base, OR num_dig==MAX for the locked base: digit is consumed but dropped; acc and num_dig unchanged; erro_digito=1 for the next cycle.
  - Otherwise: acc <= acc*base + digito, num_dig+1, latency 1 cycle.
  - Multiply realisation: acc*10 = (acc<<3)+(acc<<1), acc*8 = acc<<3, acc*16 = acc<<4.
  - acc is 10 bits; the maximum reachable is 999.
- `valor_vivo` = acc[7:0], updated the same edge as acc.
- Commit (`confirmar` in ENTRADA, `limpar`=0):
  - valor <= (acc>255) ? 255 : acc[7:0]; overflow <= (acc>255).
  - valor_valid=1 during CONCLUIDO (exactly 1 cycle).
  - acc, num_dig and base lock are cleared on entering CONCLUIDO.
  - Commit with num_dig=0 publishes valor=0, overflow=0.
- Simultaneous events:
  - limpar+confirmar: limpar wins, no valor_valid.
  - confirmar+digito_valid: digit is not accepted (ready=0), commit uses the prior acc.
  - `confirmar` during CONCLUIDO is ignored.
- `erro_digito` and `valor_valid` are registered pulses and never stretch beyond 1 cycle.
- Reset mid-entry: immediate clear of all state; no pulse is emitted on reset release.

Test Plan:
- Dec (sel=01): digits 2,5,5 then confirmar -> valor=255 (0xFF), overflow=0, valor_valid pulse 1 cycle, num_dig back to 0.
- Dec: digits 9,9,9 then confirmar -> valor_vivo shows 0xE7 (999 mod 256) before commit; valor=255, overflow=1.
- Hex (sel=10): digits A,3 then a third digit 7 -> third rejected with erro_digito pulse; confirmar -> valor=0xA3. Oct (sel=11): digits 3,7,7 -> valor=255; digit 8 in octal -> erro_digito, acc unchanged.
- Base lock: sel=11, enter 1; switch sel=01; enter 9 -> rejected (9>=8); enter 2 -> confirmar gives valor=10 (octal 12).
- Collisions: enter 4,2; assert limpar and confirmar together -> no valor_valid, acc=0, valor keeps prior value. Then confirmar+digito_valid(5) in the same cycle -> valor=0, digit not accepted.
- Reset: rst_n low asynchronously mid-entry (acc=42) -> all outputs 0 immediately, before the next clk edge. sel=00 with any digit -> erro_digito, num_dig stays 0.

Source files
------------

// File: rtl/entrada_base_bin.sv
// entrada_base_bin
// Sequential digit-entry converter. Accepts one 4-bit digit per valid/ready
// handshake in the selected base (decimal, octal or hex) and accumulates a
// binary operand. `confirmar` publishes the result, saturated to 8 bits, and
// `limpar` aborts the entry in progress.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   sel[1:0]      base select: 01=dec, 10=hex, 11=oct, 00=no base
//   digito[3:0]   offered digit value
//   digito_valid  digit offered this cycle
//   digito_ready  digit consumed when valid && ready
//   limpar        abort entry, clear accumulator
//   confirmar     end entry, publish result
//   valor[7:0]    committed (saturated) result
//   valor_valid   one-cycle pulse while the new result is published
//   valor_vivo    low 8 bits of the running accumulator
//   overflow      committed result exceeded 255
//   erro_digito   one-cycle pulse: offered digit was rejected
//   num_dig[1:0]  digits accepted in the current entry
//
// state     | meaning
// ENTRADA   | collecting digits, waiting for confirmar
// CONCLUIDO | result published this cycle (valor_valid high), back next cycle
module entrada_base_bin #(
   parameter int MAX_DIG_DEC = 3,
   parameter int MAX_DIG_OC  = 3,
   parameter int MAX_DIG_HEX = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] sel,
   input  logic [3:0] digito,
   input  logic       digito_valid,
   output logic       digito_ready,
   input  logic       limpar,
   input  logic       confirmar,
   output logic [7:0] valor,
   output logic       valor_valid,
   output logic [7:0] valor_vivo,
   output logic       overflow,
   output logic       erro_digito,
   output logic [1:0] num_dig
);

   localparam logic [1:0] LP_MAX_DEC = 2'(MAX_DIG_DEC);
   localparam logic [1:0] LP_MAX_OC  = 2'(MAX_DIG_OC);
   localparam logic [1:0] LP_MAX_HEX = 2'(MAX_DIG_HEX);

   typedef enum logic {ENTRADA = 1'b0, CONCLUIDO = 1'b1} estado_t;

   estado_t     r_estado;
   logic [9:0]  r_acc;
   logic [1:0]  r_num_dig;
   logic [1:0]  r_sel_lck;
   logic [7:0]  r_valor;
   logic        r_valor_valid;
   logic        r_overflow;
   logic        r_erro;

   logic        w_ready;
   logic [1:0]  w_sel_ef;
   logic [4:0]  w_base;
   logic [1:0]  w_max;
   logic [9:0]  w_acc_mul;
   logic [9:0]  w_acc_nxt;
   logic        w_rejeita;

   assign w_ready = (r_estado == ENTRADA) && !limpar && !confirmar;

   // Until the first digit is accepted the live sel applies; afterwards the
   // base captured with that first digit is used.
   assign w_sel_ef = (r_num_dig == 2'd0) ? sel : r_sel_lck;

   // Digit limits keep the accumulator within 999, so the truncated shifts
   // below never lose significant bits.
   always_comb begin
      w_base    = 5'd0;
      w_max     = 2'd0;
      w_acc_mul = 10'd0;
      case (w_sel_ef)
         2'b01: begin
            w_base    = 5'd10;
            w_max     = LP_MAX_DEC;
            w_acc_mul = {r_acc[6:0], 3'b000} + {r_acc[8:0], 1'b0};
         end
         2'b10: begin
            w_base    = 5'd16;
            w_max     = LP_MAX_HEX;
            w_acc_mul = {r_acc[5:0], 4'b0000};
         end
         2'b11: begin
            w_base    = 5'd8;
            w_max     = LP_MAX_OC;
            w_acc_mul = {r_acc[6:0], 3'b000};
         end
         default: begin
            w_base    = 5'd0;
            w_max     = 2'd0;
            w_acc_mul = 10'd0;
         end
      endcase
   end

   assign w_acc_nxt = w_acc_mul + {6'd0, digito};
   assign w_rejeita = (w_base == 5'd0) || ({1'b0, digito} >= w_base)
                      || (r_num_dig >= w_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado      <= ENTRADA;
         r_acc         <= 10'd0;
         r_num_dig     <= 2'd0;
         r_sel_lck     <= 2'b00;
         r_valor       <= 8'd0;
         r_valor_valid <= 1'b0;
         r_overflow    <= 1'b0;
         r_erro        <= 1'b0;
      end else begin
         r_valor_valid <= 1'b0;
         r_erro        <= 1'b0;
         if (limpar) begin
            r_estado  <= ENTRADA;
            r_acc     <= 10'd0;
            r_num_dig <= 2'd0;
            r_sel_lck <= 2'b00;
         end else if (r_estado == CONCLUIDO) begin
            r_estado <= ENTRADA;
         end else if (confirmar) begin
            r_valor       <= (r_acc > 10'd255) ? 8'hFF : r_acc[7:0];
            r_overflow    <= (r_acc > 10'd255);
            r_valor_valid <= 1'b1;
            r_estado      <= CONCLUIDO;
            r_acc         <= 10'd0;
            r_num_dig     <= 2'd0;
            r_sel_lck     <= 2'b00;
         end else if (digito_valid) begin
            if (w_rejeita) begin
               r_erro <= 1'b1;
            end else begin
               if (r_num_dig == 2'd0) begin
                  r_sel_lck <= sel;
               end
               r_acc     <= w_acc_nxt;
               r_num_dig <= r_num_dig + 2'd1;
            end
         end
      end
   end

   assign digito_ready = w_ready;
   assign valor        = r_valor;
   assign valor_valid  = r_valor_valid;
   assign valor_vivo   = r_acc[7:0];
   assign overflow     = r_overflow;
   assign erro_digito  = r_erro;
   assign num_dig      = r_num_dig;

endmodule

// File: tb/tb_entrada_base_bin.sv
module tb_entrada_base_bin;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] sel = 2'b00;
   logic [3:0] digito = 4'd0;
   logic       digito_valid = 1'b0;
   logic       limpar = 1'b0;
   logic       confirmar = 1'b0;
   logic       digito_ready;
   logic [7:0] valor;
   logic       valor_valid;
   logic [7:0] valor_vivo;
   logic       overflow;
   logic       erro_digito;
   logic [1:0] num_dig;

   entrada_base_bin #(.MAX_DIG_DEC(3), .MAX_DIG_OC(3), .MAX_DIG_HEX(2)) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .digito(digito),
      .digito_valid(digito_valid), .digito_ready(digito_ready),
      .limpar(limpar), .confirmar(confirmar), .valor(valor),
      .valor_valid(valor_valid), .valor_vivo(valor_vivo), .overflow(overflow),
      .erro_digito(erro_digito), .num_dig(num_dig)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   // Reference model: plain integer arithmetic on the entry rules.
   int m_acc, m_nd, m_lsel, m_valor;
   bit m_conc, m_ovf, m_vv, m_err;

   function automatic int base_of(input int s);
      case (s)
         1: return 10;
         2: return 16;
         3: return 8;
         default: return 0;
      endcase
   endfunction

   function automatic int max_of(input int s);
      case (s)
         1: return 3;
         2: return 2;
         3: return 3;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      m_acc = 0; m_nd = 0; m_lsel = 0; m_valor = 0;
      m_conc = 0; m_ovf = 0; m_vv = 0; m_err = 0;
   endtask

   task automatic cmp_all();
      chk("valor", int'(valor), m_valor);
      chk("valor_valid", int'(valor_valid), int'(m_vv));
      chk("valor_vivo", int'(valor_vivo), m_acc % 256);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("erro_digito", int'(erro_digito), int'(m_err));
      chk("num_dig", int'(num_dig), m_nd);
   endtask

   // One clock: drive inputs, check ready, advance model, check outputs after the edge.
   task automatic cycle(input bit v, input int d, input bit lim, input bit conf);
      int s, b;
      bit exp_ready;
      digito_valid = v; digito = 4'(d); limpar = lim; confirmar = conf;
      #1;
      exp_ready = !m_conc && !lim && !conf;
      chk("digito_ready", int'(digito_ready), int'(exp_ready));
      m_vv = 0; m_err = 0;
      if (lim) begin
         m_conc = 0; m_acc = 0; m_nd = 0;
      end else if (m_conc) begin
         m_conc = 0;
      end else if (conf) begin
         m_valor = (m_acc > 255) ? 255 : m_acc;
         m_ovf = (m_acc > 255);
         m_vv = 1; m_conc = 1; m_acc = 0; m_nd = 0;
      end else if (v) begin
         s = (m_nd == 0) ? int'(sel) : m_lsel;
         b = base_of(s);
         if (b == 0 || d >= b || m_nd >= max_of(s)) m_err = 1;
         else begin
            if (m_nd == 0) m_lsel = int'(sel);
            m_acc = m_acc * b + d;
            m_nd++;
         end
      end
      @(posedge clk);
      #1;
      cmp_all();
      digito_valid = 1'b0; limpar = 1'b0; confirmar = 1'b0;
   endtask

   task automatic dig(input int d);
      cycle(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic conf_c();
      cycle(1'b0, 0, 1'b0, 1'b1);
   endtask

   initial begin
      model_reset();
      #3;
      cmp_all();
      chk("reset_valor_lit", int'(valor), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // decimal 255
      sel = 2'b01;
      dig(2); dig(5); dig(5);
      chk("dec_vivo_lit", int'(valor_vivo), 255);
      conf_c();
      chk("dec255_valor_lit", int'(valor), 255);
      chk("dec255_vv_lit", int'(valor_valid), 1);
      chk("dec255_ovf_lit", int'(overflow), 0);
      cycle(0, 0, 0, 1);                 // confirmar in CONCLUIDO ignored
      chk("dec255_vv_end_lit", int'(valor_valid), 0);
      chk("dec255_nd_lit", int'(num_dig), 0);

      // decimal 999 saturates
      dig(9); dig(9); dig(9);
      chk("dec999_vivo_lit", int'(valor_vivo), 8'hE7);
      dig(1);
      chk("dec_max_err_lit", int'(erro_digito), 1);
      conf_c();
      chk("dec999_valor_lit", int'(valor), 255);
      chk("dec999_ovf_lit", int'(overflow), 1);
      cycle(0, 0, 0, 0);

      // hex A3, third digit rejected
      sel = 2'b10;
      dig(10); dig(3); dig(7);
      chk("hex_third_err_lit", int'(erro_digito), 1);
      conf_c();
      chk("hexA3_lit", int'(valor), 8'hA3);
      cycle(0, 0, 0, 0);

      // octal 377 and an illegal 8
      sel = 2'b11;
      dig(3); dig(8);
      chk("oct8_err_lit", int'(erro_digito), 1);
      chk("oct8_nd_lit", int'(num_dig), 1);
      dig(7); dig(7);
      conf_c();
      chk("oct377_lit", int'(valor), 255);
      cycle(0, 0, 0, 0);

      // base lock: octal 1, switch to dec, 9 rejected, 2 -> octal 12
      sel = 2'b11; dig(1);
      sel = 2'b01; dig(9);
      chk("lock_err_lit", int'(erro_digito), 1);
      dig(2);
      conf_c();
      chk("lock_oct12_lit", int'(valor), 10);
      cycle(0, 0, 0, 0);

      // collisions
      dig(4); dig(2);
      cycle(0, 0, 1, 1);
      chk("coll_vv_lit", int'(valor_valid), 0);
      chk("coll_keep_lit", int'(valor), 10);
      cycle(1, 5, 0, 1);
      chk("conf_dig_valor_lit", int'(valor), 0);
      chk("conf_dig_vv_lit", int'(valor_valid), 1);
      cycle(0, 0, 0, 0);

      // no base
      sel = 2'b00; dig(3);
      chk("nobase_err_lit", int'(erro_digito), 1);
      chk("nobase_nd_lit", int'(num_dig), 0);

      // async reset mid-entry (acc = 42), after publishing a nonzero valor
      sel = 2'b01; dig(7); conf_c(); cycle(0, 0, 0, 0);
      dig(4); dig(2);
      chk("pre_rst_vivo_lit", int'(valor_vivo), 42);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_vivo_lit", int'(valor_vivo), 0);
      chk("rst_valor_lit", int'(valor), 0);
      chk("rst_nd_lit", int'(num_dig), 0);
      model_reset();
      cmp_all();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int d;
         bit v, l, c;
         if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
         v = ($urandom_range(0, 9) < 6);
         d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
         l = ($urandom_range(0, 39) == 0);
         c = ($urandom_range(0, 9) == 0);
         cycle(v, d, l, c);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
